// File: rtl/simple_in_n_out_pkg.sv
// Shared types and default sizes for the simple_in_n_out exhaustive sweeper.
package simple_in_n_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int SWEEP_N_IN  = 3;
    localparam int SWEEP_N_OUT = 2;
    localparam int SWEEP_SIG_W = 8;

endpackage

// File: rtl/sweep_signature.sv
// Rotate-left-by-one then XOR accumulator; reusable on the monitor side.
module sweep_signature #(
    parameter int SIG_W = 8,
    parameter int DIN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
        return (v << 1) | (v >> (SIG_W - 1));
    endfunction

    // Clear wins over accumulate; din is zero-extended into the signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= rotl1(sig) ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/simple_in_n_out_sweeper.sv
// Walks the simple_in_n_out inputs through every combination, waits a
// programmable settle time, then hands (vector, result) pairs downstream
// over valid/ready while accumulating a result signature.
module simple_in_n_out_sweeper
    import simple_in_n_out_pkg::*;
#(
    parameter int N_IN   = SWEEP_N_IN,
    parameter int N_OUT  = SWEEP_N_OUT,
    parameter int SETTLE = 1,
    parameter int SIG_W  = SWEEP_SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] res_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N_IN-1:0]  res_vec,
    output logic [N_OUT-1:0] res_data,
    output logic [SIG_W-1:0] signature,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    sweep_state_t     state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             last_vec;
    logic             handshake;
    logic             sig_clear;

    assign last_vec  = &vec_out;
    assign handshake = (state == EMIT) && res_ready && !abort;
    // The signature is cleared on an accepted start so a finished or
    // aborted sweep keeps its value visible while sitting in IDLE.
    assign sig_clear = (state == IDLE) && start && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = DRIVE;
            DRIVE: if (cnt == CNT_W'(1)) next_state = EMIT;
            EMIT:  if (res_ready) next_state = last_vec ? DONE : DRIVE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // Status outputs are registered from the next state so busy rises
    // together with the first DRIVE cycle and done is a clean pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (next_state == DRIVE) || (next_state == EMIT);
            res_valid <= (next_state == EMIT);
            done      <= (next_state == DONE);
        end
    end

    // Stimulus vector, settle counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out  <= '0;
            cnt      <= CNT_W'(SETTLE);
            res_vec  <= '0;
            res_data <= '0;
        end else if (abort) begin
            vec_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vec_out <= '0;
                    cnt     <= CNT_W'(SETTLE);
                end
                DRIVE: begin
                    if (cnt == CNT_W'(1)) begin
                        res_data <= res_in;
                        res_vec  <= vec_out;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                EMIT: begin
                    // All-ones ends the sweep, so the increment never wraps.
                    if (res_ready && !last_vec) begin
                        vec_out <= vec_out + N_IN'(1);
                        cnt     <= CNT_W'(SETTLE);
                    end
                end
                default: ;
            endcase
        end
    end

    sweep_signature #(
        .SIG_W (SIG_W),
        .DIN_W (N_OUT)
    ) u_sig (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sig_clear),
        .en    (handshake),
        .din   (res_data),
        .sig   (signature)
    );

endmodule

// File: tb/tb_simple_in_n_out_sweeper.sv
// Bench for simple_in_n_out_sweeper: a SETTLE=1 and a SETTLE=3 instance,
// a lookup-table UUT, and a sweep-level model of pairs, timing and signature.
module tb_simple_in_n_out_sweeper;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, res_ready;
    bit         sel;
    logic [1:0] lut [0:7];

    logic [2:0] vec_a, vec_b, rvec_a, rvec_b;
    logic [1:0] rin_a, rin_b, rdata_a, rdata_b;
    logic [7:0] sig_a, sig_b;
    logic       val_a, val_b, busy_a, busy_b, done_a, done_b;

    logic [2:0] o_vec, o_rvec;
    logic [1:0] o_rdata;
    logic [7:0] o_sig;
    logic       o_valid, o_busy, o_done;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rin_a = lut[vec_a];
    assign rin_b = lut[vec_b];

    assign o_vec   = sel ? vec_b   : vec_a;
    assign o_rvec  = sel ? rvec_b  : rvec_a;
    assign o_rdata = sel ? rdata_b : rdata_a;
    assign o_sig   = sel ? sig_b   : sig_a;
    assign o_valid = sel ? val_b   : val_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;

    simple_in_n_out_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(1), .SIG_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort),
        .vec_out(vec_a), .res_in(rin_a), .res_valid(val_a), .res_ready(res_ready),
        .res_vec(rvec_a), .res_data(rdata_a), .signature(sig_a),
        .busy(busy_a), .done(done_a)
    );

    simple_in_n_out_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(3), .SIG_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort),
        .vec_out(vec_b), .res_in(rin_b), .res_valid(val_b), .res_ready(res_ready),
        .res_vec(rvec_b), .res_data(rdata_b), .signature(sig_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signature step in plain arithmetic: doubling mod 256 plus the carried-out MSB.
    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [1:0] r);
        int v;
        v = ((int'(s) * 2) % 256) + (int'(s) / 128);
        return 8'(v ^ int'(r));
    endfunction

    // mode: 0 ready high, 1 four stall cycles on vector 3, 2 random ready.
    task automatic run_sweep(input bit which, input int s, input int mode,
                             input int abort_at, input int restart_at);
        int         idx = 0;
        int         stalls = 0;
        int         stall_left = 4;
        int         first_valid = -1;
        int         k, t, ndone;
        logic [7:0] msig = 8'h00;
        bit         finished = 1'b0;
        bit         aborted = 1'b0;

        sel = which;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc - 1;
        for (int n = 0; n < 400 && !finished; n++) begin
            t = cyc - k;
            if (t == 1) check("busy_rise", {31'd0, o_busy}, 32'd1);
            if (o_busy) check("vec_out", {29'd0, o_vec}, idx);
            if (o_valid) begin
                if (first_valid < 0) begin
                    first_valid = t;
                    check("first_valid", t, s + 1);
                end
                check("res_vec", {29'd0, o_rvec}, idx);
                check("res_data", {30'd0, o_rdata}, {30'd0, lut[idx]});
            end
            if (o_done) begin
                check("done_time", t, 8 * (s + 1) + 1 + stalls);
                check("done_count", idx, 8);
                check("signature", {24'd0, o_sig}, {24'd0, msig});
                finished = 1'b1;
            end
            if (!finished) begin
                if (mode == 1) begin
                    if (o_valid && idx == 3 && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end else if (mode == 2) begin
                    res_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    res_ready = 1'b1;
                end
                abort = (t == abort_at);
                start = (t == restart_at);
                if (abort) aborted = 1'b1;
                if (o_valid && res_ready && !abort) begin
                    msig = sig_step(msig, lut[idx]);
                    idx++;
                end else if (o_valid && !res_ready) begin
                    stalls++;
                end
                @(negedge clk);
                start = 1'b0;
                if (aborted) begin
                    abort = 1'b0;
                    check("abort_valid", {31'd0, o_valid}, 32'd0);
                    check("abort_busy", {31'd0, o_busy}, 32'd0);
                    check("abort_vec", {29'd0, o_vec}, 32'd0);
                    check("abort_sig", {24'd0, o_sig}, {24'd0, msig});
                    ndone = 0;
                    repeat (20) begin
                        if (o_done) ndone++;
                        @(negedge clk);
                    end
                    check("abort_no_done", ndone, 0);
                    finished = 1'b1;
                end
            end
        end
        if (!finished) check("sweep_timeout", 0, 1);
        res_ready = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        sel       = 1'b0;
        for (int i = 0; i < 8; i++) lut[i] = 2'(i);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_vec", {26'd0, vec_a, vec_b}, 32'd0);
        check("rst_valid", {30'd0, val_a, val_b}, 32'd0);
        check("rst_res_vec", {26'd0, rvec_a, rvec_b}, 32'd0);
        check("rst_res_data", {28'd0, rdata_a, rdata_b}, 32'd0);
        check("rst_sig", {16'd0, sig_a, sig_b}, 32'd0);
        check("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        check("rst_done", {30'd0, done_a, done_b}, 32'd0);

        run_sweep(0, 1, 0, -1, -1);
        check("golden_plain", {24'd0, o_sig}, 32'h33);

        run_sweep(0, 1, 1, -1, -1);
        check("golden_stall", {24'd0, o_sig}, 32'h33);

        run_sweep(0, 1, 0, 6, -1);
        run_sweep(0, 1, 0, -1, -1);
        check("golden_after_abort", {24'd0, o_sig}, 32'h33);

        run_sweep(0, 1, 0, -1, 5);
        check("golden_restart", {24'd0, o_sig}, 32'h33);

        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check("start_abort_idle", {31'd0, busy_a}, 32'd0);

        run_sweep(1, 3, 0, -1, -1);
        check("golden_settle3", {24'd0, o_sig}, 32'h33);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) lut[i] = 2'($urandom_range(0, 3));
            run_sweep(r[0], r[0] ? 3 : 1, 2, -1, -1);
        end

        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_busy", {31'd0, busy_a}, 32'd0);
        check("async_valid", {31'd0, val_a}, 32'd0);
        check("async_vec", {29'd0, vec_a}, 32'd0);
        check("async_sig", {24'd0, sig_a}, 32'd0);
        check("async_res_vec", {29'd0, rvec_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("async_no_done", {31'd0, done_a}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
